// File: rtl/ddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ddr_pkg
// Description : Shared DDR write-path defaults, pool FSM states and burst decode.
// Revision    : 1.0 - initial release
// ============================================================================
package ddr_pkg;

    localparam int c_depth_default     = 8;
    localparam int c_addr_size_default = 8;
    localparam int c_tid_size_default  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } wpool_state_t;

    // Burst length code to beat count: 0/1/2/3 -> 1/2/4/8 beats.
    function automatic logic [3:0] burst_len(input logic [1:0] code);
        return 4'd1 << code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/write_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : write_cmd_fifo
// Description : Circular command store with head read; push on full is legal
//               only together with a pop (the freed slot is reused).
// Revision    : 1.0 - initial release
// ============================================================================
module write_cmd_fifo #(
    parameter int DEPTH     = 8,
    parameter int ADDR_SIZE = 8,
    parameter int TID_SIZE  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [ADDR_SIZE-1:0]     push_addr,
    input  logic [TID_SIZE-1:0]      push_tid,
    input  logic                     pop,
    output logic                     full,
    output logic                     empty,
    output logic [ADDR_SIZE-1:0]     head_addr,
    output logic [TID_SIZE-1:0]      head_tid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic [ADDR_SIZE-1:0] r_addr_mem [DEPTH];
    logic [TID_SIZE-1:0]  r_tid_mem  [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_pop;
    logic                 w_push;

    assign full      = (r_count == c_cnt_w'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_pop     = pop && !empty;
    assign w_push    = push && (!full || w_pop);
    assign head_addr = r_addr_mem[r_rd_ptr];
    assign head_tid  = r_tid_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr_mem[r_wr_ptr] <= push_addr;
            r_tid_mem[r_wr_ptr]  <= push_tid;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/write_command_pool.sv
`default_nettype none
// ============================================================================
// Module      : write_command_pool
// Description : Write command pool: queues write commands and expands the head
//               into a burst of beats, blocking issue on read-pool hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module write_command_pool
    import ddr_pkg::*;
#(
    parameter int DEPTH     = c_depth_default,
    parameter int ADDR_SIZE = c_addr_size_default,
    parameter int TID_SIZE  = c_tid_size_default
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wstrobe,
    input  logic [ADDR_SIZE-1:0]   waddr_in,
    input  logic [TID_SIZE-1:0]    wtid_in,
    input  logic [1:0]             burst_size,
    input  logic                   issue,
    input  logic                   busy,
    input  logic                   rvalid,
    input  logic [ADDR_SIZE-1:0]   raddr,
    input  logic [TID_SIZE-1:0]    rtid,
    output logic                   wready,
    output logic [ADDR_SIZE-1:0]   waddr,
    output logic [TID_SIZE-1:0]    wtid,
    output logic                   wbeat_valid,
    output logic                   wlast,
    output logic                   werr,
    output logic [$clog2(DEPTH):0] count
);

    wpool_state_t         r_state;
    wpool_state_t         w_next_state;
    logic [2:0]           r_beat;
    logic [3:0]           r_len;
    logic                 r_werr;

    logic                 w_full;
    logic                 w_empty;
    logic [ADDR_SIZE-1:0] w_head_addr;
    logic [TID_SIZE-1:0]  w_head_tid;
    logic [$clog2(DEPTH):0] w_count;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_hazard;
    logic                 w_is_last;
    logic                 w_start;
    logic                 w_wready;
    logic                 w_beat_valid;
    logic                 w_last;
    logic [ADDR_SIZE-1:0] w_addr;

    write_cmd_fifo #(
        .DEPTH     (DEPTH),
        .ADDR_SIZE (ADDR_SIZE),
        .TID_SIZE  (TID_SIZE)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_addr (waddr_in),
        .push_tid  (wtid_in),
        .pop       (w_pop),
        .full      (w_full),
        .empty     (w_empty),
        .head_addr (w_head_addr),
        .head_tid  (w_head_tid),
        .count     (w_count)
    );

    // A read from another ID inside the same burst-aligned block blocks issue.
    assign w_hazard  = rvalid
                     && ((raddr >> burst_size) == (w_head_addr >> burst_size))
                     && (rtid != w_head_tid);
    assign w_is_last = ({1'b0, r_beat} == (r_len - 4'd1));

    always_comb begin
        w_next_state = r_state;
        w_wready     = 1'b0;
        w_beat_valid = 1'b0;
        w_last       = 1'b0;
        w_start      = 1'b0;
        w_addr       = w_empty ? '0 : w_head_addr;
        case (r_state)
            IDLE: begin
                w_wready = !w_empty && !w_hazard;
                if (issue && w_wready) begin
                    w_start      = 1'b1;
                    w_next_state = BURST;
                end
            end
            BURST: begin
                w_beat_valid = !busy;
                w_last       = w_is_last && !busy;
                w_addr       = w_head_addr + ADDR_SIZE'(r_beat);
                if (w_last) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Final beat frees the head slot, so a push on a full pool is accepted then.
    assign w_pop  = w_last;
    assign w_push = wstrobe && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_beat  <= '0;
            r_len   <= '0;
            r_werr  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_werr  <= wstrobe && !w_push;
            if (w_start) begin
                r_beat <= '0;
                r_len  <= burst_len(burst_size);
            end else if (r_state == BURST && !busy && !w_is_last) begin
                r_beat <= r_beat + 3'd1;
            end
        end
    end

    assign wready      = w_wready && !rst;
    assign wbeat_valid = w_beat_valid && !rst;
    assign wlast       = w_last && !rst;
    assign werr        = r_werr && !rst;
    assign waddr       = rst ? '0 : w_addr;
    assign wtid        = (rst || w_empty) ? '0 : w_head_tid;
    assign count       = rst ? '0 : w_count;

endmodule
`default_nettype wire

// File: tb/tb_write_command_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_write_command_pool
// Description : Randomized + directed scoreboard bench for write_command_pool.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_write_command_pool;

    typedef struct {
        logic [7:0] addr;
        logic [1:0] tid;
    } cmd_t;

    typedef struct {
        logic [7:0] addr;
        logic [1:0] tid;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst, wstrobe, issue, busy, rvalid;
    logic [7:0] waddr_in, raddr, waddr;
    logic [1:0] wtid_in, burst_size, rtid, wtid;
    logic       wready, wbeat_valid, wlast, werr;
    logic [3:0] count;

    int vectors     = 0;
    int miscompares = 0;

    cmd_t  q[$];
    beat_t exp_beats[$];
    bit    in_burst = 1'b0;
    bit    werr_exp = 1'b0;
    int    beat     = 0;
    int    len      = 1;

    write_command_pool dut (
        .clk         (clk),
        .rst         (rst),
        .wstrobe     (wstrobe),
        .waddr_in    (waddr_in),
        .wtid_in     (wtid_in),
        .burst_size  (burst_size),
        .issue       (issue),
        .busy        (busy),
        .rvalid      (rvalid),
        .raddr       (raddr),
        .rtid        (rtid),
        .wready      (wready),
        .waddr       (waddr),
        .wtid        (wtid),
        .wbeat_valid (wbeat_valid),
        .wlast       (wlast),
        .werr        (werr),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Beat monitor: every presented beat must match the next expected one.
    always @(negedge clk) begin
        if (wbeat_valid === 1'b1) begin
            if (exp_beats.size() == 0) begin
                chk("beat_unexpected", 32'(wbeat_valid), 32'd0);
            end else begin
                beat_t b;
                b = exp_beats.pop_front();
                chk("beat_addr", 32'(waddr), 32'(b.addr));
                chk("beat_tid", 32'(wtid), 32'(b.tid));
                chk("beat_last", 32'(wlast), 32'(b.last));
            end
        end
    end

    // One clock of stimulus; model predicts outputs from queue-level rules.
    task automatic cyc(input logic r, input logic ws, input logic [7:0] wa, input logic [1:0] wt,
                       input logic [1:0] bs, input logic is, input logic bz, input logic rv,
                       input logic [7:0] ra, input logic [1:0] rt);
        bit         hz, e_rdy, pop, acc;
        logic [7:0] e_addr;
        cmd_t       h;
        int         blk;
        rst = r; wstrobe = ws; waddr_in = wa; wtid_in = wt; burst_size = bs;
        issue = is; busy = bz; rvalid = rv; raddr = ra; rtid = rt;
        @(negedge clk);
        if (r) begin
            chk("rst_wready", 32'(wready), 32'd0);
            chk("rst_count", 32'(count), 32'd0);
            chk("rst_werr", 32'(werr), 32'd0);
            chk("rst_wbeat_valid", 32'(wbeat_valid), 32'd0);
            chk("rst_wlast", 32'(wlast), 32'd0);
            chk("rst_waddr", 32'(waddr), 32'd0);
            chk("rst_wtid", 32'(wtid), 32'd0);
            q.delete();
            exp_beats.delete();
            in_burst = 1'b0;
            werr_exp = 1'b0;
            beat     = 0;
        end else begin
            h   = (q.size() != 0) ? q[0] : '{addr: 8'h00, tid: 2'b00};
            blk = 1 << bs;
            hz  = rv && (q.size() != 0) && ((int'(ra) / blk) == (int'(h.addr) / blk)) && (rt != h.tid);
            e_rdy  = !in_burst && (q.size() != 0) && !hz;
            e_addr = in_burst ? 8'(int'(h.addr) + beat) : h.addr;
            pop    = in_burst && !bz && (beat == len - 1);
            chk("wready", 32'(wready), 32'(e_rdy));
            chk("count", 32'(count), 32'(q.size()));
            chk("werr", 32'(werr), 32'(werr_exp));
            chk("wtid", 32'(wtid), 32'(h.tid));
            chk("waddr", 32'(waddr), 32'(e_addr));
            chk("wbeat_valid", 32'(wbeat_valid), 32'(in_burst && !bz));
            chk("wlast", 32'(wlast), 32'(pop));
            acc = ws && (q.size() < 8 || pop);
            if (in_burst && !bz) begin
                if (pop) begin
                    void'(q.pop_front());
                    in_burst = 1'b0;
                end else begin
                    beat++;
                end
            end else if (!in_burst && is && e_rdy) begin
                in_burst = 1'b1;
                beat     = 0;
                len      = blk;
                for (int i = 0; i < len; i++)
                    exp_beats.push_back('{addr: 8'(int'(h.addr) + i), tid: h.tid, last: (i == len - 1)});
            end
            if (acc) q.push_back('{addr: wa, tid: wt});
            werr_exp = ws && !acc;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    endtask

    task automatic push(input logic [7:0] a, input logic [1:0] t);
        cyc(1'b0, 1'b1, a, t, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    endtask

    task automatic start(input logic [1:0] bs);
        cyc(1'b0, 1'b0, 8'h00, 2'd0, bs, 1'b1, 1'b0, 1'b0, 8'h00, 2'd0);
    endtask

    initial begin
        repeat (2) cyc(1'b1, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);

        // Single-beat burst.
        push(8'h20, 2'd0);
        start(2'd0);
        idle(2);

        // Four beats with a two-cycle stall on beat 1.
        push(8'h44, 2'd1);
        start(2'd2);
        idle(1);
        repeat (2) cyc(1'b0, 1'b0, 8'h00, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0);
        idle(4);

        // Hazard compare against an 8-beat block.
        push(8'hB4, 2'd0);
        cyc(1'b0, 1'b0, 8'h00, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 8'hB7, 2'd1);
        cyc(1'b0, 1'b0, 8'h00, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 8'hB7, 2'd0);
        cyc(1'b0, 1'b0, 8'h00, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1, 8'hC0, 2'd1);

        // Fill to 8, overflow, then push alongside a final-beat pop.
        repeat (7) push(8'($urandom), 2'($urandom));
        push(8'h99, 2'd3);
        idle(1);
        start(2'd0);
        push(8'h55, 2'd2);
        repeat (24) start(2'd0);

        // Address wrap inside a burst.
        push(8'hFE, 2'd1);
        start(2'd2);
        idle(5);

        // Reset during beat 2 of an 8-beat burst.
        push(8'h10, 2'd2);
        start(2'd3);
        idle(2);
        cyc(1'b1, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            logic [7:0] ra;
            ra = ((q.size() != 0) && ($urandom_range(0, 1) == 1)) ? (q[0].addr ^ 8'($urandom_range(0, 15)))
                                                                   : 8'($urandom);
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, 8'($urandom), 2'($urandom),
                2'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 2) == 0, ra, 2'($urandom));
        end

        idle(20);
        chk("beats_left", 32'(exp_beats.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/write_command_pool.md
WRITE_COMMAND_POOL -- requirements
Module: write_command_pool

Interface
REQ-001 Parameter DEPTH, default 8, is the number of command entries and SHALL be a power of two.
REQ-002 Parameter ADDR_SIZE, default 8, is the command address width.
REQ-003 Parameter TID_SIZE, default 2, is the transaction ID width.
REQ-004 The port list SHALL be as follows, in this order:
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  reset, synchronous, active-high
- wstrobe  in  1  push the write command on waddr_in/wtid_in this cycle
- waddr_in  in  ADDR_SIZE  write base address
- wtid_in  in  TID_SIZE  write transaction ID
- burst_size  in  2  burst length code: length = 1 << burst_size (1/2/4/8 beats)
- issue  in  1  scheduler accepts the head command
- busy  in  1  memory stall; holds the current beat
- rvalid  in  1  read pool head is valid
- raddr  in  ADDR_SIZE  read pool head address
- rtid  in  TID_SIZE  read pool head ID
- wready  out  1  head command may be issued
- waddr  out  ADDR_SIZE  address of the current beat
- wtid  out  TID_SIZE  ID of the head command
- wbeat_valid  out  1  a write beat is being presented this cycle
- wlast  out  1  final beat of the burst
- werr  out  1  one-cycle pulse: a push was dropped
- count  out  log2(DEPTH)+1  number of occupied entries

Function
REQ-005 Entries SHALL be stored in a circular FIFO; head and tail pointers SHALL wrap modulo DEPTH.
REQ-006 A push SHALL be accepted when wstrobe=1 and either count<DEPTH or the head entry is popped in the same cycle.
REQ-007 A push that is not accepted SHALL be dropped, SHALL NOT change FIFO state, and SHALL set werr=1 for exactly the following cycle.
REQ-008 count SHALL equal pushes minus pops, and SHALL be unchanged on a simultaneous push and pop.
REQ-009 The FSM SHALL have the states IDLE and BURST.
REQ-010 hazard SHALL equal rvalid & ((raddr >> burst_size) == (head_addr >> burst_size)) & (rtid != head_tid).
REQ-011 In IDLE, wready SHALL equal (count != 0) & !hazard; in BURST, wready SHALL be 0.
REQ-012 In IDLE, issue with wready=1 SHALL move the FSM to BURST, clear the beat counter, and latch len = 1 << burst_size.
REQ-013 issue SHALL be ignored when wready=0 and when in BURST.
REQ-014 In BURST:
- wbeat_valid SHALL equal !busy.
- waddr SHALL equal (head_addr + beat) mod 2^ADDR_SIZE.
- wlast SHALL equal (beat == len-1) & !busy.
REQ-015 When busy=1, beat, waddr and all state SHALL hold.
REQ-016 wlast=1 SHALL pop the head entry and return the FSM to IDLE in the same edge, so the next head can be issued on the following cycle (no bubble).
REQ-017 burst_size changes while in BURST SHALL NOT affect the burst in flight.
REQ-018 In IDLE, wbeat_valid and wlast SHALL be 0.
REQ-019 In IDLE, waddr SHALL present the head address, or 0 when the FIFO is empty.
REQ-020 wtid SHALL present the head ID, or 0 when the FIFO is empty.

Reset
REQ-021 While rst=1, the pointers, count, beat and len SHALL be 0, the FSM SHALL be IDLE, and werr SHALL be 0.
REQ-022 With the block in reset, all outputs SHALL be 0.
REQ-023 rst asserted mid-burst SHALL discard the burst and all stored entries, with no wlast generated.

Structure
REQ-024 The shared package ddr_pkg SHALL hold the DEPTH/ADDR_SIZE/TID_SIZE defaults, the wpool_state_t enum {IDLE, BURST}, and the burst-length decode function.
REQ-025 Storage and pointers SHALL live in one sub-module, write_cmd_fifo, with push/pop/full/empty and head-read ports.
REQ-026 The FSM, beat counter and hazard compare SHALL be in the top level.

Verification
REQ-027 Push (0x20, tid0); burst_size=0; issue -> 1 beat: waddr=0x20, wlast=1 the next cycle; count goes 1->0.
REQ-028 burst_size=2; push 0x44; issue; busy=1 on beat 1 for 2 cycles -> waddr sequence 0x44, 0x45 (held), 0x46, 0x47; wlast only on 0x47.
REQ-029 burst_size=3; head 0xB4 tid0; rvalid=1:
- raddr=0xB7 rtid=1 -> wready=0
- raddr=0xB7 rtid=0 -> wready=1
- raddr=0xC0 rtid=1 -> wready=1
REQ-030 Push 8 entries, then a 9th -> werr=1 for 1 cycle and count=8; push on the same cycle as a final-beat pop -> accepted and count stays 8.
REQ-031 Push 0xFE with burst_size=2 and issue -> waddr 0xFE, 0xFF, 0x00, 0x01 (address wrap).
REQ-032 Assert rst during beat 2 of an 8-beat burst -> next cycle: count=0, wbeat_valid=0, wready=0.
